// File: rtl/tx_seq_pkg.sv
// Shared state encoding and line levels for the asynchronous frame transmitter.
package tx_seq_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/tx_tick_counter.sv
// Bit-period counter: counts 0..max while enabled, pulses wrap on the last count.
module tx_tick_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         nrst,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] max,
   output logic         wrap
);

   logic [W-1:0] count;

   assign wrap = en && (count == max);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (wrap) begin
         count <= '0;
      end else if (en) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/tx_frame_sequencer.sv
// Serial transmitter: start bit, LSB-first data, optional even parity, stop bits.
module tx_frame_sequencer
   import tx_seq_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_W       = 8,
   parameter int PARITY_EN    = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   input  logic              abort,
   output logic              tx_serial,
   output logic              tx_busy,
   output logic              frame_done
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(DATA_W);
   localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_W - 1);
   localparam logic          LAST_STOP = (STOP_BITS == 2);

   tx_state_t         state, state_n;
   logic [DATA_W-1:0] shift, shift_n;
   logic [IW-1:0]     idx, idx_n;
   logic              stop_cnt, stop_n;
   logic              par, par_n;
   logic              serial_q, serial_n;
   logic              done_q, done_n;
   logic              bit_end;
   logic              tick_clr;
   logic              tick_en;

   assign tick_en  = (state != IDLE);
   assign tick_clr = (state == IDLE) || abort;

   tx_tick_counter #(
      .W (TW)
   ) u_tick (
      .clk  (clk),
      .nrst (nrst),
      .en   (tick_en),
      .clr  (tick_clr),
      .max  (TW'(CLKS_PER_BIT - 1)),
      .wrap (bit_end)
   );

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state    <= IDLE;
         shift    <= '0;
         idx      <= '0;
         stop_cnt <= 1'b0;
         par      <= 1'b0;
         serial_q <= IDLE_LEVEL;
         done_q   <= 1'b0;
      end else begin
         state    <= state_n;
         shift    <= shift_n;
         idx      <= idx_n;
         stop_cnt <= stop_n;
         par      <= par_n;
         serial_q <= serial_n;
         done_q   <= done_n;
      end
   end

   // Abort outranks bit_end; the line level is registered alongside the state.
   always_comb begin
      state_n  = state;
      shift_n  = shift;
      idx_n    = idx;
      stop_n   = stop_cnt;
      par_n    = par;
      serial_n = serial_q;
      done_n   = 1'b0;
      if (state == IDLE) begin
         serial_n = IDLE_LEVEL;
         if (tx_valid) begin
            state_n  = START;
            shift_n  = tx_data;
            par_n    = ^tx_data;
            idx_n    = '0;
            stop_n   = 1'b0;
            serial_n = START_LEVEL;
         end
      end else if (abort) begin
         state_n  = IDLE;
         idx_n    = '0;
         stop_n   = 1'b0;
         serial_n = IDLE_LEVEL;
      end else if (bit_end) begin
         case (state)
            START: begin
               state_n  = DATA;
               serial_n = shift[0];
            end
            DATA: begin
               if (idx == LAST_IDX) begin
                  idx_n = '0;
                  if (PARITY_EN != 0) begin
                     state_n  = PARITY;
                     serial_n = par;
                  end else begin
                     state_n  = STOP;
                     serial_n = IDLE_LEVEL;
                  end
               end else begin
                  shift_n  = shift >> 1;
                  idx_n    = idx + IW'(1);
                  serial_n = shift[1];
               end
            end
            PARITY: begin
               state_n  = STOP;
               serial_n = IDLE_LEVEL;
            end
            STOP: begin
               serial_n = IDLE_LEVEL;
               if (stop_cnt == LAST_STOP) begin
                  state_n = IDLE;
                  stop_n  = 1'b0;
                  done_n  = 1'b1;
               end else begin
                  stop_n = 1'b1;
               end
            end
            default: begin
               state_n  = IDLE;
               serial_n = IDLE_LEVEL;
            end
         endcase
      end
   end

   assign tx_ready   = (state == IDLE);
   assign tx_busy    = (state != IDLE);
   assign tx_serial  = serial_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Bench for tx_frame_sequencer: three configurations checked against a frame-level model.
module tb_tx_frame_sequencer;

   logic       clk = 1'b0;
   logic       nrst;
   logic [7:0] d0, d1;
   logic [4:0] d2;
   logic [2:0] valid, abort;
   logic [2:0] serial, ready, busy, done;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   tx_frame_sequencer #(.CLKS_PER_BIT(16), .DATA_W(8), .PARITY_EN(0), .STOP_BITS(1)) u0 (
      .clk(clk), .nrst(nrst), .tx_data(d0), .tx_valid(valid[0]), .tx_ready(ready[0]),
      .abort(abort[0]), .tx_serial(serial[0]), .tx_busy(busy[0]), .frame_done(done[0]));

   tx_frame_sequencer #(.CLKS_PER_BIT(16), .DATA_W(8), .PARITY_EN(1), .STOP_BITS(2)) u1 (
      .clk(clk), .nrst(nrst), .tx_data(d1), .tx_valid(valid[1]), .tx_ready(ready[1]),
      .abort(abort[1]), .tx_serial(serial[1]), .tx_busy(busy[1]), .frame_done(done[1]));

   tx_frame_sequencer #(.CLKS_PER_BIT(2), .DATA_W(5), .PARITY_EN(0), .STOP_BITS(1)) u2 (
      .clk(clk), .nrst(nrst), .tx_data(d2), .tx_valid(valid[2]), .tx_ready(ready[2]),
      .abort(abort[2]), .tx_serial(serial[2]), .tx_busy(busy[2]), .frame_done(done[2]));

   function automatic int cpb_of(int u);
      return (u == 2) ? 2 : 16;
   endfunction

   function automatic int dw_of(int u);
      return (u == 2) ? 5 : 8;
   endfunction

   function automatic int par_of(int u);
      return (u == 1) ? 1 : 0;
   endfunction

   function automatic int stb_of(int u);
      return (u == 1) ? 2 : 1;
   endfunction

   function automatic int frame_len(int u);
      return (1 + dw_of(u) + par_of(u) + stb_of(u)) * cpb_of(u);
   endfunction

   // Line level k cycles after the accept edge, derived from the frame layout.
   function automatic logic exp_level(int u, logic [15:0] w, int k);
      int b, dw;
      logic [15:0] m;
      dw = dw_of(u);
      b  = k / cpb_of(u);
      m  = (16'd1 << dw) - 16'd1;
      if (b == 0) return 1'b0;
      if (b <= dw) return w[b-1];
      if (par_of(u) == 1 && b == dw + 1) return ^(w & m);
      return 1'b1;
   endfunction

   task automatic drive(int u, logic v, logic [15:0] w);
      valid[u] = v;
      case (u)
         0: d0 = w[7:0];
         1: d1 = w[7:0];
         default: d2 = w[4:0];
      endcase
   endtask

   task automatic run_frame(int u, logic [15:0] w, string tag);
      int f;
      f = frame_len(u);
      @(negedge clk);
      drive(u, 1'b1, w);
      @(posedge clk);
      @(negedge clk);
      drive(u, 1'b0, 16'($urandom));
      for (int k = 0; k <= f + 1; k++) begin
         if (k > 0) @(negedge clk);
         n_checks += 4;
         if (serial[u] !== exp_level(u, w, k)) begin
            n_fail++;
            $display("FAIL %s serial u%0d k=%0d got %b want %b", tag, u, k, serial[u], exp_level(u, w, k));
         end
         if (done[u] !== (k == f)) begin
            n_fail++;
            $display("FAIL %s frame_done u%0d k=%0d got %b want %b", tag, u, k, done[u], (k == f));
         end
         if (ready[u] !== (k >= f)) begin
            n_fail++;
            $display("FAIL %s tx_ready u%0d k=%0d got %b want %b", tag, u, k, ready[u], (k >= f));
         end
         if (busy[u] !== (k < f)) begin
            n_fail++;
            $display("FAIL %s tx_busy u%0d k=%0d got %b want %b", tag, u, k, busy[u], (k < f));
         end
      end
   endtask

   task automatic test_reset();
      nrst = 1'b0;
      valid = '0;
      abort = '0;
      d0 = '0; d1 = '0; d2 = '0;
      repeat (2) @(negedge clk);
      for (int u = 0; u < 3; u++) begin
         n_checks += 4;
         if (serial[u] !== 1'b1) begin n_fail++; $display("FAIL reset serial u%0d got %b want 1", u, serial[u]); end
         if (done[u] !== 1'b0)   begin n_fail++; $display("FAIL reset done u%0d got %b want 0", u, done[u]); end
         if (ready[u] !== 1'b1)  begin n_fail++; $display("FAIL reset ready u%0d got %b want 1", u, ready[u]); end
         if (busy[u] !== 1'b0)   begin n_fail++; $display("FAIL reset busy u%0d got %b want 0", u, busy[u]); end
      end
      nrst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_default_frame();
      run_frame(0, 16'h00A5, "default_a5");
      for (int i = 0; i < 3; i++) run_frame(0, 16'($urandom), "default_rand");
   endtask

   task automatic test_parity_two_stop();
      run_frame(1, 16'h0007, "parity_07");
      for (int i = 0; i < 3; i++) run_frame(1, 16'($urandom), "parity_rand");
   endtask

   task automatic test_small_config();
      run_frame(2, 16'h001F, "small_1f");
      for (int i = 0; i < 4; i++) run_frame(2, 16'($urandom), "small_rand");
   endtask

   task automatic test_back_to_back();
      int f;
      logic [15:0] w1, w2;
      logic es, ed, eb;
      f = frame_len(0);
      w1 = 16'h0055;
      w2 = 16'h00C3;
      @(negedge clk);
      drive(0, 1'b1, w1);
      @(posedge clk);
      @(negedge clk);
      drive(0, 1'b1, w2);
      for (int k = 0; k <= 2 * f + 2; k++) begin
         if (k > 0) @(negedge clk);
         if (k < f) es = exp_level(0, w1, k);
         else if (k == f) es = 1'b1;
         else es = exp_level(0, w2, k - f - 1);
         ed = (k == f) || (k == 2 * f + 1);
         eb = !((k == f) || (k >= 2 * f + 1));
         n_checks += 3;
         if (serial[0] !== es) begin n_fail++; $display("FAIL b2b serial k=%0d got %b want %b", k, serial[0], es); end
         if (done[0] !== ed)   begin n_fail++; $display("FAIL b2b done k=%0d got %b want %b", k, done[0], ed); end
         if (busy[0] !== eb)   begin n_fail++; $display("FAIL b2b busy k=%0d got %b want %b", k, busy[0], eb); end
         if (k == f + 1) drive(0, 1'b0, '0);
      end
   endtask

   task automatic test_abort();
      int f;
      logic [15:0] w;
      f = frame_len(0);
      w = 16'($urandom);
      @(negedge clk);
      drive(0, 1'b1, w);
      @(posedge clk);
      @(negedge clk);
      drive(0, 1'b0, '0);
      // Data bit index 3 starts at k=64; raise abort five cycles into it.
      for (int k = 1; k <= 69; k++) @(negedge clk);
      n_checks++;
      if (serial[0] !== w[3]) begin n_fail++; $display("FAIL abort pre serial got %b want %b", serial[0], w[3]); end
      abort[0] = 1'b1;
      @(negedge clk);
      abort[0] = 1'b0;
      n_checks += 4;
      if (serial[0] !== 1'b1) begin n_fail++; $display("FAIL abort serial got %b want 1", serial[0]); end
      if (ready[0] !== 1'b1)  begin n_fail++; $display("FAIL abort ready got %b want 1", ready[0]); end
      if (busy[0] !== 1'b0)   begin n_fail++; $display("FAIL abort busy got %b want 0", busy[0]); end
      if (done[0] !== 1'b0)   begin n_fail++; $display("FAIL abort done got %b want 0", done[0]); end
      for (int k = 0; k < f; k++) begin
         @(negedge clk);
         n_checks++;
         if (done[0] !== 1'b0 || serial[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL abort idle k=%0d done=%b serial=%b want 0/1", k, done[0], serial[0]);
         end
      end
      // Abort raised while idle must not block the accept on the same edge.
      abort[0] = 1'b1;
      drive(0, 1'b1, 16'h00FF);
      @(posedge clk);
      @(negedge clk);
      abort[0] = 1'b0;
      drive(0, 1'b0, '0);
      for (int k = 0; k <= f + 1; k++) begin
         if (k > 0) @(negedge clk);
         n_checks += 2;
         if (serial[0] !== exp_level(0, 16'h00FF, k)) begin
            n_fail++;
            $display("FAIL abort_ff serial k=%0d got %b want %b", k, serial[0], exp_level(0, 16'h00FF, k));
         end
         if (done[0] !== (k == f)) begin
            n_fail++;
            $display("FAIL abort_ff done k=%0d got %b want %b", k, done[0], (k == f));
         end
      end
   endtask

   task automatic test_reset_mid_stop();
      logic [15:0] w;
      w = 16'($urandom);
      @(negedge clk);
      drive(0, 1'b1, w);
      @(posedge clk);
      @(negedge clk);
      drive(0, 1'b0, '0);
      for (int k = 1; k <= 150; k++) @(negedge clk);
      n_checks++;
      if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL rst_stop pre busy got %b want 1", busy[0]); end
      nrst = 1'b0;
      #1;
      n_checks += 4;
      if (serial[0] !== 1'b1) begin n_fail++; $display("FAIL rst_stop serial got %b want 1", serial[0]); end
      if (busy[0] !== 1'b0)   begin n_fail++; $display("FAIL rst_stop busy got %b want 0", busy[0]); end
      if (done[0] !== 1'b0)   begin n_fail++; $display("FAIL rst_stop done got %b want 0", done[0]); end
      if (ready[0] !== 1'b1)  begin n_fail++; $display("FAIL rst_stop ready got %b want 1", ready[0]); end
      repeat (2) @(negedge clk);
      nrst = 1'b1;
      for (int k = 0; k < 24; k++) begin
         @(negedge clk);
         n_checks++;
         if (done[0] !== 1'b0 || serial[0] !== 1'b1 || busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_stop after k=%0d done=%b serial=%b busy=%b want 0/1/0", k, done[0], serial[0], busy[0]);
         end
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_default_frame();
      test_parity_two_stop();
      test_small_config();
      test_back_to_back();
      test_abort();
      test_reset_mid_stop();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tx_frame_sequencer.md
Name: tx_frame_sequencer

Overview:
Serial transmit controller that sequences a bit-period tick counter and a shift register to emit one asynchronous frame per accepted word: start bit, data LSB-first, optional even parity, then stop bits. It sits between the transmit message buffer, which supplies words over a valid/ready handshake, and the serial output pin. It owns the bit-timing counter and decides when that counter runs, clears and wraps.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 2..1024; tick counter width is $clog2(CLKS_PER_BIT).
DATA_W, 8, data bits per frame; legal range 5..16.
PARITY_EN, 0, 1 inserts an even-parity bit after the data bits.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  in  1  system clock, rising edge.
nrst  in  1  reset, asynchronous, active-low.
tx_data  in  DATA_W  word to send; sampled only on the accept edge.
tx_valid  in  1  upstream has a word.
tx_ready  out  1  sequencer can accept a word; high only in IDLE.
abort  in  1  synchronous abort of the frame in flight.
tx_serial  out  1  serial line; idles high; registered.
tx_busy  out  1  high in every state except IDLE.
frame_done  out  1  one-cycle registered pulse marking completion of a full frame.

Behaviour:
- Reset (nrst=0, asynchronous): state=IDLE, tick count=0, bit index=0, shift reg=0, tx_serial=1, frame_done=0, tx_busy=0, tx_ready=1.
- States: IDLE, START, DATA, PARITY, STOP.
- Accept: a word is accepted on a rising edge with tx_valid&&tx_ready. On that edge tx_data loads into the shift reg, parity = ^tx_data is latched, the tick counter clears, state goes to START and tx_serial goes to 0.
- tx_data and tx_valid are ignored outside IDLE.
- Tick counter: enabled in every non-IDLE state. Counts 0..CLKS_PER_BIT-1. bit_end = enable && count==CLKS_PER_BIT-1; on bit_end the count wraps to 0. Held at 0 in IDLE.
- Each bit_end edge advances the sequence:
  - START -> DATA; tx_serial=shift[0].
  - DATA: shift right, bit index +1, tx_serial=next LSB.
  - After bit index DATA_W-1 -> PARITY if PARITY_EN (tx_serial=parity), else STOP (tx_serial=1).
  - PARITY -> STOP; tx_serial=1.
  - STOP: a stop-bit counter counts STOP_BITS periods. The final bit_end -> IDLE, tx_serial=1, frame_done=1 for exactly the next cycle.
- Every bit, start bit included, is held for exactly CLKS_PER_BIT cycles.
- Frame length: F=(1+DATA_W+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles from the accept edge E0 to the IDLE-entry edge E0+F.
- Back-to-back: tx_ready is high in the first IDLE cycle, the same cycle as frame_done. A word accepted on edge E0+F+1 therefore gives exactly one idle-high cycle between frames.
- Abort: has priority over bit_end. Abort in any non-IDLE state -> IDLE on the next edge: tx_serial=1, counters cleared, no frame_done. Abort in IDLE has no effect; if tx_valid is high on that edge, the word is still accepted.
- Reset asserted mid-frame returns every output to its reset value immediately; no frame_done is emitted.

Decomposition:
- Package tx_seq_pkg holds:
  - typedef enum logic [2:0] tx_state_t {IDLE, START, DATA, PARITY, STOP};
  - localparam IDLE_LEVEL=1'b1 and START_LEVEL=1'b0.
- Sub-module tx_tick_counter #(W):
  - inputs: clk, nrst, en, clr, max[W-1:0]; output: wrap.
  - wrap is a combinational pulse when en && count==max; the counter wraps to 0 on that edge. clr has priority over en.
  - The sequencer instantiates it with max=CLKS_PER_BIT-1.

Test Plan:
- Defaults, send 0xA5 at edge E0 -> tx_serial reads 0,1,0,1,0,0,1,0,1,1 with each bit 16 cycles long; tx_ready=0 over E0..E160; frame_done high only in cycle E160..E161; tx_busy low from E160.
- PARITY_EN=1, STOP_BITS=2, send 0x07 -> data 1,1,1,0,0,0,0,0, then parity bit 1, then 32 cycles high; frame_done at E0+192.
- tx_valid held high with 0x55 then 0xC3 queued -> second start bit begins at E0+161; line is high for exactly 1 cycle between frames.
- abort asserted 5 cycles into the DATA bit at index 3 -> tx_serial=1 and state=IDLE next cycle; no frame_done; tx_ready=1; a new word of 0xFF then sends correctly.
- nrst pulsed low mid-STOP -> tx_serial=1, tx_busy=0, frame_done=0 asynchronously; no pulse after release.
- CLKS_PER_BIT=2, DATA_W=5, send 0x1F -> start bit 2 cycles, data 1,1,1,1,1 each 2 cycles; frame_done at E0+14.
